// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: state encoding and shared fixed-point defaults for the decoder layer.
`default_nettype none

package fixed_point_pkg;

  localparam int FRAC_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fixed_point_add.sv
// fixed_point_add: signed fixed-point sum, wrapping modulo 2^BITSIZE.
`default_nettype none

module fixed_point_add #(
  parameter int BITSIZE = 32
) (
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  output logic signed [BITSIZE-1:0] sum
);

  assign sum = a + b;

endmodule

`default_nettype wire

// File: rtl/fixed_point_multiply.sv
// fixed_point_multiply: signed fixed-point product, truncated toward minus infinity.
`default_nettype none

module fixed_point_multiply
  import fixed_point_pkg::*;
#(
  parameter int BITSIZE = 32,
  parameter int FRAC    = FRAC_DEFAULT
) (
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  output logic signed [BITSIZE-1:0] p
);

  logic signed [2*BITSIZE-1:0] prod;

  // Arithmetic shift of the full product drops fraction bits toward minus infinity.
  assign prod = (2*BITSIZE)'(a) * (2*BITSIZE)'(b);
  assign p    = BITSIZE'(prod >>> FRAC);

endmodule

`default_nettype wire

// File: rtl/decoder_fixed_point.sv
// decoder_fixed_point: dense layer out(j) = b(j) + sum_i x(i)*w(j,i), one multiplier and one adder shared over time.
`default_nettype none

module decoder_fixed_point
  import fixed_point_pkg::*;
#(
  parameter int N_input  = 4,
  parameter int M_output = 9,
  parameter int BITSIZE  = 32,
  parameter int FRAC     = FRAC_DEFAULT
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic signed [N_input*BITSIZE-1:0]          x,
  input  logic signed [N_input*M_output*BITSIZE-1:0] w,
  input  logic signed [M_output*BITSIZE-1:0]         b,
  output logic signed [M_output*BITSIZE-1:0]         out,
  output logic                                     busy,
  output logic                                     done
);

  localparam int IW = (N_input > 1) ? $clog2(N_input) : 1;
  localparam int JW = $clog2(M_output + 1);
  localparam int KW = $clog2(N_input * M_output + 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_input - 1);
  localparam logic [JW-1:0] J_LAST = JW'(M_output - 1);

  state_t state, state_next;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;  // flat weight index, equals j*N_input + i during MAC

  logic signed [BITSIZE-1:0] x_in    [N_input];
  logic signed [BITSIZE-1:0] w_in    [N_input*M_output];
  logic signed [BITSIZE-1:0] b_in    [M_output];
  logic signed [BITSIZE-1:0] x_reg   [N_input];
  logic signed [BITSIZE-1:0] b_reg   [M_output];
  logic signed [BITSIZE-1:0] out_reg [M_output];
  logic signed [BITSIZE-1:0] acc, product, addend, sum;

  for (genvar n = 0; n < N_input; n++) begin : g_x
    assign x_in[n] = x[n*BITSIZE +: BITSIZE];
  end

  for (genvar n = 0; n < N_input*M_output; n++) begin : g_w
    assign w_in[n] = w[n*BITSIZE +: BITSIZE];
  end

  for (genvar n = 0; n < M_output; n++) begin : g_bo
    assign b_in[n]                 = b[n*BITSIZE +: BITSIZE];
    assign out[n*BITSIZE +: BITSIZE] = out_reg[n];
  end

  fixed_point_multiply #(.BITSIZE(BITSIZE), .FRAC(FRAC)) u_mul (
    .a(x_reg[i]),
    .b(w_in[k]),
    .p(product)
  );

  assign addend = (state == BIAS) ? b_reg[j] : product;

  fixed_point_add #(.BITSIZE(BITSIZE)) u_add (
    .a  (acc),
    .b  (addend),
    .sum(sum)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (i == I_LAST) state_next = BIAS;
      BIAS:    state_next = (j == J_LAST) ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
      for (int n = 0; n < N_input; n++)  x_reg[n] <= '0;
      for (int n = 0; n < M_output; n++) begin
        b_reg[n]   <= '0;
        out_reg[n] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= '0;
          i   <= '0;
          j   <= '0;
          k   <= '0;
          for (int n = 0; n < N_input; n++)  x_reg[n] <= x_in[n];
          for (int n = 0; n < M_output; n++) b_reg[n] <= b_in[n];
        end
        MAC: begin
          acc <= sum;
          i   <= i + IW'(1);
          k   <= k + KW'(1);
        end
        BIAS: begin
          out_reg[j] <= sum;
          acc        <= '0;
          i          <= '0;
          j          <= j + JW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_fixed_point.sv
// tb_decoder_fixed_point: directed and randomized layer evaluations against a plain-arithmetic reference.
`default_nettype none

module tb_decoder_fixed_point;

  localparam int N      = 4;
  localparam int M      = 9;
  localparam int BW     = 32;
  localparam int LAT    = M * (N + 1);
  localparam int PERIOD = LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  logic [31:0] xv [N];
  logic [31:0] wv [N*M];
  logic [31:0] bv [M];
  logic [31:0] cap [N];
  logic [31:0] hx [3][N];

  logic signed [N*BW-1:0]   x_bus;
  logic signed [N*M*BW-1:0] w_bus;
  logic signed [M*BW-1:0]   b_bus;
  logic signed [M*BW-1:0]   out_bus;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    x_bus = '0;
    w_bus = '0;
    b_bus = '0;
    for (int i = 0; i < N; i++)   x_bus[i*BW +: BW] = xv[i];
    for (int i = 0; i < N*M; i++) w_bus[i*BW +: BW] = wv[i];
    for (int i = 0; i < M; i++)   b_bus[i*BW +: BW] = bv[i];
  end

  decoder_fixed_point dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x_bus),
    .w    (w_bus),
    .b    (b_bus),
    .out  (out_bus),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: bias plus truncated Q-format products, all modulo 2^32.
  function automatic logic [31:0] model(input logic [31:0] xa [N], input int j);
    logic [31:0] acc;
    longint p;
    acc = bv[j];
    for (int i = 0; i < N; i++) begin
      p   = longint'($signed(xa[i])) * longint'($signed(wv[j*N + i]));
      acc = acc + 32'(p >>> 16);
    end
    return acc;
  endfunction

  function automatic logic [31:0] out_word(input int j);
    return out_bus[j*BW +: BW];
  endfunction

  task automatic check_model(input string tag, input logic [31:0] xa [N]);
    for (int j = 0; j < M; j++)
      check($sformatf("%s out%0d", tag, j), out_word(j), model(xa, j));
  endtask

  task automatic check_const(input string tag, input logic [31:0] exp);
    for (int j = 0; j < M; j++)
      check($sformatf("%s const out%0d", tag, j), out_word(j), exp);
  endtask

  task automatic fill(input logic [31:0] xs, input logic [31:0] ws, input logic [31:0] bs);
    for (int i = 0; i < N; i++)   xv[i] = xs;
    for (int i = 0; i < N*M; i++) wv[i] = ws;
    for (int i = 0; i < M; i++)   bv[i] = bs;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)   xv[i] = $urandom;
    for (int i = 0; i < N*M; i++) wv[i] = $urandom;
    for (int i = 0; i < M; i++)   bv[i] = $urandom;
  endtask

  // One evaluation; optional extra start pulse or reset at a given edge count after the start edge.
  task automatic run(input string tag, input int extra_edge, input int rst_edge);
    int t;
    int stray;
    bit aborted;
    t = 0;
    aborted = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < N; i++) cap[i] = xv[i];
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) xv[i] = $urandom;
    while (!done && t < LAT + 20) begin
      @(posedge clk);
      #1;
      t++;
      start = (t == extra_edge);
      if (t == 1) check({tag, " busy"}, 32'(busy), 32'd1);
      if (t == rst_edge) begin
        rst = 1'b1;
        #1;
        check({tag, " rst busy"}, 32'(busy), 32'd0);
        check({tag, " rst done"}, 32'(done), 32'd0);
        check_const({tag, " rst"}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
        break;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check({tag, " latency"}, 32'(t), 32'(LAT));
      check_model(tag, cap);
      @(posedge clk);
      #1;
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
      stray = 0;
      repeat (PERIOD) begin
        @(posedge clk);
        #1;
        if (busy || done) stray++;
      end
      check({tag, " no rerun"}, 32'(stray), 32'd0);
    end
  endtask

  initial begin
    fill(32'h0, 32'h0, 32'h0);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) hx[r][i] = $urandom;

    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_const("reset", 32'h0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("start during rst ignored", 32'(busy), 32'd0);

    fill(32'h0001_0000, 32'h0000_8000, 32'h0);
    run("half", 0, 0);
    check_const("half", 32'h0002_0000);

    fill(32'h0002_0000, 32'hFFFF_0000, 32'h0000_4000);
    run("neg", 0, 0);
    check_const("neg", 32'hFFF8_4000);

    fill(32'h7FFF_0000, 32'h0001_0000, 32'h0);
    run("wrap", 0, 0);
    check_const("wrap", 32'hFFFC_0000);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run($sformatf("rand%0d", r), 0, 0);
    end

    fill_random();
    run("restart ignored", 10, 0);

    fill_random();
    run("midrst", 0, 20);
    fill_random();
    run("after rst", 0, 0);

    // Start held high: each run must use the x present at its own start edge.
    fill_random();
    begin
      int t;
      int r;
      t = 0;
      @(negedge clk);
      for (int i = 0; i < N; i++) xv[i] = hx[0][i];
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) xv[i] = hx[1][i];
      while (t < 3 * PERIOD - 2) begin
        @(posedge clk);
        #1;
        t++;
        r = t / PERIOD;
        if (t % PERIOD == 0 && r < 2)
          for (int i = 0; i < N; i++) xv[i] = hx[r + 1][i];
        if (done || (t % PERIOD == LAT)) begin
          check($sformatf("hold done t%0d", t), 32'(done), 32'(t % PERIOD == LAT));
          for (int i = 0; i < N; i++) cap[i] = hx[r][i];
          check_model($sformatf("hold run%0d", r), cap);
        end
      end
      start = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
